// File: rtl/std_dffbe_wrarb.sv
// rtl/std_dffbe_wrarb.sv - round-robin write arbiter and commit sequencer for a bit-enable register bank
//
// Ports:
//   clk, resetn         clock (rising edge) and asynchronous active-low reset
//   req_valid/req_lock  per-requester request valid and hold-grant-after-beat
//   req_mask/req_data   per-requester bit mask and data, slice i = requester i
//   req_ready           one-hot-or-zero accept
//   hold                stall: commit stage must not write the bank
//   bank_en/bank_d      per-bit enable and data driven to the bank
//   done_valid/done_id  commit pulse and requester index of the committed beat
//   locked              arbiter is in the LOCKED state
module std_dffbe_wrarb #(
  parameter int NUM_REQ   = 4,
  parameter int DFF_WIDTH = 32,
  parameter int ID_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ*DFF_WIDTH-1:0] req_mask,
  input  logic [NUM_REQ*DFF_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         hold,
  output logic [DFF_WIDTH-1:0]         bank_en,
  output logic [DFF_WIDTH-1:0]         bank_d,
  output logic                         done_valid,
  output logic [ID_WIDTH-1:0]          done_id,
  output logic                         locked
);

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                state, state_next;
  logic [ID_WIDTH-1:0]   owner, owner_next;
  logic [ID_WIDTH-1:0]   rr_ptr, ptr_next;

  logic                  stage_valid;
  logic [DFF_WIDTH-1:0]  stage_mask;
  logic [DFF_WIDTH-1:0]  stage_data;
  logic [ID_WIDTH-1:0]   stage_id;
  logic [DFF_WIDTH-1:0]  last_d;

  logic                  cand_found;
  logic [ID_WIDTH-1:0]   cand_id;
  logic [ID_WIDTH-1:0]   scan_id;
  logic                  can_accept;
  logic                  handshake;
  logic                  grant_lock;
  logic                  commit;

  // Modulo-NUM_REQ increment; works for non-power-of-two requester counts.
  function automatic logic [ID_WIDTH-1:0] inc_id(input logic [ID_WIDTH-1:0] id);
    inc_id = (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  // Candidate selection: owner only while locked, else first valid from rr_ptr.
  always_comb begin
    cand_found = 1'b0;
    cand_id    = '0;
    scan_id    = rr_ptr;
    if (state == S_LOCKED) begin
      cand_found = req_valid[owner];
      cand_id    = owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!cand_found && req_valid[scan_id]) begin
          cand_found = 1'b1;
          cand_id    = scan_id;
        end
        scan_id = inc_id(scan_id);
      end
    end
  end

  // A full stage can still accept when it drains in the same cycle.
  assign can_accept = !stage_valid || !hold;
  assign handshake  = resetn && cand_found && can_accept;
  assign grant_lock = req_lock[cand_id];
  assign commit     = stage_valid && !hold;

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[cand_id] = 1'b1;
  end

  // Lock FSM: state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      rr_ptr <= ptr_next;
    end
  end

  // Lock FSM: next state. rr_ptr only moves when a grant ends a sequence.
  always_comb begin
    state_next = state;
    owner_next = owner;
    ptr_next   = rr_ptr;
    if (handshake) begin
      case (state)
        S_IDLE: begin
          if (grant_lock) begin
            state_next = S_LOCKED;
            owner_next = cand_id;
          end else begin
            ptr_next = inc_id(cand_id);
          end
        end
        S_LOCKED: begin
          if (!grant_lock) begin
            state_next = S_IDLE;
            ptr_next   = inc_id(owner);
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Lock FSM and commit-stage outputs.
  always_comb begin
    locked     = (state == S_LOCKED);
    done_valid = commit;
    done_id    = commit ? stage_id   : '0;
    bank_en    = commit ? stage_mask : '0;
    bank_d     = commit ? stage_data : last_d;
  end

  // Single-entry commit stage; a new beat overwrites a draining one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_valid <= 1'b0;
      stage_mask  <= '0;
      stage_data  <= '0;
      stage_id    <= '0;
    end else if (handshake) begin
      stage_valid <= 1'b1;
      stage_mask  <= req_mask[int'(cand_id)*DFF_WIDTH +: DFF_WIDTH];
      stage_data  <= req_data[int'(cand_id)*DFF_WIDTH +: DFF_WIDTH];
      stage_id    <= cand_id;
    end else if (commit) begin
      stage_valid <= 1'b0;
    end
  end

  // bank_d keeps the last committed word between commits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_d <= '0;
    else if (commit) last_d <= stage_data;
  end

endmodule

// File: tb/tb_std_dffbe_wrarb.sv
// tb/tb_std_dffbe_wrarb.sv - self-checking bench for std_dffbe_wrarb
module tb_std_dffbe_wrarb;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic              clk;
  logic              resetn;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_lock;
  logic [N*W-1:0]    req_mask;
  logic [N*W-1:0]    req_data;
  logic [N-1:0]      req_ready;
  logic              hold;
  logic [W-1:0]      bank_en;
  logic [W-1:0]      bank_d;
  logic              done_valid;
  logic [IW-1:0]     done_id;
  logic              locked;

  int checks;
  int failures;

  std_dffbe_wrarb #(.NUM_REQ(N), .DFF_WIDTH(W), .ID_WIDTH(IW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_mask(req_mask), .req_data(req_data),
    .req_ready(req_ready), .hold(hold),
    .bank_en(bank_en), .bank_d(bank_d),
    .done_valid(done_valid), .done_id(done_id),
    .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_valid = '0;
    req_lock  = '0;
    req_mask  = '0;
    req_data  = '0;
    hold      = 1'b0;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] m, input logic [W-1:0] d);
    req_mask[i*W +: W] = m;
    req_data[i*W +: W] = d;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    clear_inputs();
    req_valid = '1;
    repeat (2) @(posedge clk);
    #4;
    checks += 6;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    if (bank_en !== '0) begin failures++; $display("FAIL reset_bank_en got=%h exp=0", bank_en); end
    if (bank_d !== '0) begin failures++; $display("FAIL reset_bank_d got=%h exp=0", bank_d); end
    if (done_valid !== 1'b0) begin failures++; $display("FAIL reset_done_valid got=%b exp=0", done_valid); end
    if (done_id !== '0) begin failures++; $display("FAIL reset_done_id got=%0d exp=0", done_id); end
    if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
  endtask

  task automatic test_round_robin;
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N; i++) set_req(i, 32'hFFFF_FFFF, 32'h1111_1111 * (i + 1));
    for (int c = 0; c < 8; c++) begin
      #3;
      checks++;
      if (req_ready !== 4'(1 << (c % N))) begin
        failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, 4'(1 << (c % N)));
      end
      if (c > 0) begin
        checks += 4;
        if (done_valid !== 1'b1) begin failures++; $display("FAIL rr_done_valid c=%0d got=%b exp=1", c, done_valid); end
        if (done_id !== IW'((c - 1) % N)) begin failures++; $display("FAIL rr_done_id c=%0d got=%0d exp=%0d", c, done_id, (c - 1) % N); end
        if (bank_en !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rr_bank_en c=%0d got=%h exp=ffffffff", c, bank_en); end
        if (bank_d !== 32'h1111_1111 * ((c - 1) % N + 1)) begin
          failures++; $display("FAIL rr_bank_d c=%0d got=%h exp=%h", c, bank_d, 32'h1111_1111 * ((c - 1) % N + 1));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_single;
    do_reset();
    req_valid = 4'b0100;
    set_req(2, 32'h0000_FF00, 32'hAAAA_AAAA);
    #3;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    next_cycle();
    req_valid = '0;
    #3;
    checks += 5;
    if (bank_en !== 32'h0000_FF00) begin failures++; $display("FAIL single_bank_en got=%h exp=0000ff00", bank_en); end
    if (bank_d !== 32'hAAAA_AAAA) begin failures++; $display("FAIL single_bank_d got=%h exp=aaaaaaaa", bank_d); end
    if (done_valid !== 1'b1) begin failures++; $display("FAIL single_done_valid got=%b exp=1", done_valid); end
    if (done_id !== 2'd2) begin failures++; $display("FAIL single_done_id got=%0d exp=2", done_id); end
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_idle_ready got=%b exp=0000", req_ready); end
    next_cycle();
    #3;
    checks += 3;
    if (done_valid !== 1'b0) begin failures++; $display("FAIL single_after_dv got=%b exp=0", done_valid); end
    if (bank_en !== '0) begin failures++; $display("FAIL single_after_en got=%h exp=0", bank_en); end
    if (bank_d !== 32'hAAAA_AAAA) begin failures++; $display("FAIL single_after_d got=%h exp=aaaaaaaa", bank_d); end
  endtask

  task automatic test_lock;
    logic [3:0] exp_ready [5];
    logic       exp_lock  [5];
    logic [3:0] valids    [5];
    logic [3:0] locks     [5];
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'h0F0F_0F0F, 32'h1000 + i);
    // Beat from req 0 alone moves rr_ptr to 1, then req 1 runs a 3-beat locked sequence.
    valids    = '{4'b0001, 4'b1011, 4'b1011, 4'b1011, 4'b1001};
    locks     = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    exp_ready = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
    exp_lock  = '{1'b0,    1'b0,    1'b1,    1'b1,    1'b0};
    for (int c = 0; c < 5; c++) begin
      req_valid = valids[c];
      req_lock  = locks[c];
      #3;
      checks += 2;
      if (req_ready !== exp_ready[c]) begin failures++; $display("FAIL lock_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready[c]); end
      if (locked !== exp_lock[c]) begin failures++; $display("FAIL lock_locked c=%0d got=%b exp=%b", c, locked, exp_lock[c]); end
      if (c >= 2) begin
        checks++;
        if (done_id !== 2'd1 || done_valid !== 1'b1) begin
          failures++; $display("FAIL lock_done c=%0d got=%b/%0d exp=1/1", c, done_valid, done_id);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_hold;
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N; i++) set_req(i, 32'hFFFF_FFFF, 32'h1111_1111 * (i + 1));
    hold = 1'b1;
    #3;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL hold_empty_ready got=%b exp=0001", req_ready); end
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      #3;
      checks += 4;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL hold_ready c=%0d got=%b exp=0000", c, req_ready); end
      if (bank_en !== '0) begin failures++; $display("FAIL hold_en c=%0d got=%h exp=0", c, bank_en); end
      if (done_valid !== 1'b0) begin failures++; $display("FAIL hold_dv c=%0d got=%b exp=0", c, done_valid); end
      if (bank_d !== '0) begin failures++; $display("FAIL hold_d c=%0d got=%h exp=0", c, bank_d); end
      next_cycle();
    end
    hold = 1'b0;
    #3;
    checks += 4;
    if (done_valid !== 1'b1 || done_id !== 2'd0) begin failures++; $display("FAIL hold_release_done got=%b/%0d exp=1/0", done_valid, done_id); end
    if (bank_d !== 32'h1111_1111) begin failures++; $display("FAIL hold_release_d got=%h exp=11111111", bank_d); end
    if (bank_en !== 32'hFFFF_FFFF) begin failures++; $display("FAIL hold_release_en got=%h exp=ffffffff", bank_en); end
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL hold_release_ready got=%b exp=0010", req_ready); end
    next_cycle();
    #3;
    checks++;
    if (done_id !== 2'd1 || bank_d !== 32'h2222_2222) begin
      failures++; $display("FAIL hold_next got=%0d/%h exp=1/22222222", done_id, bank_d);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_lock;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'hFFFF_FFFF, 32'hC0DE_0000 + i);
    req_valid = 4'b0100;
    req_lock  = 4'b0100;
    #3;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL rst_lock_first got=%b exp=0100", req_ready); end
    next_cycle();
    #3;
    checks++;
    if (locked !== 1'b1 || req_ready !== 4'b0100) begin
      failures++; $display("FAIL rst_lock_second got=%b/%b exp=1/0100", locked, req_ready);
    end
    next_cycle();
    hold   = 1'b1;
    resetn = 1'b0;
    #3;
    checks += 3;
    if (done_valid !== 1'b0) begin failures++; $display("FAIL rst_lock_dv got=%b exp=0", done_valid); end
    if (locked !== 1'b0) begin failures++; $display("FAIL rst_lock_locked got=%b exp=0", locked); end
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_lock_ready got=%b exp=0000", req_ready); end
    next_cycle();
    resetn    = 1'b1;
    hold      = 1'b0;
    req_valid = 4'b1010;
    req_lock  = '0;
    #3;
    checks += 3;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL rst_lock_regrant got=%b exp=0010", req_ready); end
    if (bank_en !== '0 || done_valid !== 1'b0) begin failures++; $display("FAIL rst_lock_bank got=%h/%b exp=0/0", bank_en, done_valid); end
    if (locked !== 1'b0) begin failures++; $display("FAIL rst_lock_after got=%b exp=0", locked); end
    next_cycle();
  endtask

  task automatic test_zero_mask;
    do_reset();
    req_valid = 4'b0001;
    req_lock  = 4'b0001;
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0005);
    #3;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL zm_first got=%b exp=0001", req_ready); end
    next_cycle();
    req_lock = 4'b0000;
    set_req(0, 32'h0000_0000, 32'h1234_5678);
    #3;
    checks += 2;
    if (req_ready !== 4'b0001 || locked !== 1'b1) begin failures++; $display("FAIL zm_second got=%b/%b exp=0001/1", req_ready, locked); end
    if (bank_en !== 32'hFFFF_FFFF || done_valid !== 1'b1) begin failures++; $display("FAIL zm_first_commit got=%h/%b exp=ffffffff/1", bank_en, done_valid); end
    next_cycle();
    req_valid = '0;
    #3;
    checks += 4;
    if (done_valid !== 1'b1 || done_id !== 2'd0) begin failures++; $display("FAIL zm_done got=%b/%0d exp=1/0", done_valid, done_id); end
    if (bank_en !== '0) begin failures++; $display("FAIL zm_en got=%h exp=0", bank_en); end
    if (bank_d !== 32'h1234_5678) begin failures++; $display("FAIL zm_d got=%h exp=12345678", bank_d); end
    if (locked !== 1'b0) begin failures++; $display("FAIL zm_locked got=%b exp=0", locked); end
    next_cycle();
  endtask

  task automatic test_random;
    logic          m_sv, m_locked;
    logic [W-1:0]  m_mask, m_data, m_last;
    int            m_id, m_owner, m_ptr, grant;
    logic          m_commit;
    logic [N-1:0]  exp_ready;
    do_reset();
    m_sv = 0; m_locked = 0; m_mask = '0; m_data = '0; m_last = '0;
    m_id = 0; m_owner = 0; m_ptr = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_lock[i]  = ($urandom_range(0, 3) == 0);
        set_req(i, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, $urandom);
      end
      hold = ($urandom_range(0, 3) == 0);
      // Reference: who may win this cycle.
      grant = -1;
      if (m_locked) begin
        if (req_valid[m_owner]) grant = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (grant < 0 && req_valid[(m_ptr + k) % N]) grant = (m_ptr + k) % N;
        end
      end
      if (m_sv && hold) grant = -1;
      exp_ready = (grant >= 0) ? N'(1 << grant) : '0;
      m_commit  = m_sv && !hold;
      #3;
      checks += 5;
      if (req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
      if (done_valid !== m_commit) begin failures++; $display("FAIL rnd_dv c=%0d got=%b exp=%b", c, done_valid, m_commit); end
      if (bank_en !== (m_commit ? m_mask : '0)) begin failures++; $display("FAIL rnd_en c=%0d got=%h exp=%h", c, bank_en, m_commit ? m_mask : '0); end
      if (bank_d !== (m_commit ? m_data : m_last)) begin failures++; $display("FAIL rnd_d c=%0d got=%h exp=%h", c, bank_d, m_commit ? m_data : m_last); end
      if (locked !== m_locked) begin failures++; $display("FAIL rnd_locked c=%0d got=%b exp=%b", c, locked, m_locked); end
      if (m_commit) begin
        checks++;
        if (done_id !== IW'(m_id)) begin failures++; $display("FAIL rnd_id c=%0d got=%0d exp=%0d", c, done_id, m_id); end
        m_last = m_data;
      end
      if (grant >= 0) begin
        m_sv   = 1;
        m_mask = req_mask[grant*W +: W];
        m_data = req_data[grant*W +: W];
        m_id   = grant;
        if (req_lock[grant]) begin
          m_locked = 1;
          m_owner  = grant;
        end else begin
          m_locked = 0;
          m_ptr    = (grant + 1) % N;
        end
      end else if (m_commit) begin
        m_sv = 0;
      end
      next_cycle();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_single();
    test_lock();
    test_hold();
    test_reset_mid_lock();
    test_zero_mask();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
